// File: rtl/seq_avalon_port.sv
// seq_avalon_port: Avalon-MM responder holding two DNA sequence buffers and a direction-result FIFO
// for the alignment solver. Define SEQ_PORT_CYCLES_EN to build the RUN-cycle counter at address 6.
module seq_avalon_port #(
    parameter int MAX_LEN   = 64,
    parameter int RES_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        solve_start,
    output logic        solve_abort,
    output logic [7:0]  len1,
    output logic [7:0]  len2,
    input  logic [7:0]  seq1_addr,
    input  logic [7:0]  seq2_addr,
    output logic [1:0]  seq1_base,
    output logic [1:0]  seq2_base,
    input  logic        dir_valid,
    input  logic [1:0]  dir_data,
    input  logic        dir_last,
    output logic        dir_ready
);
    localparam int SAW = $clog2(MAX_LEN);
    localparam int FAW = $clog2(RES_DEPTH);
    localparam logic [8:0]   MAX_LEN_W = MAX_LEN[8:0];
    localparam logic [FAW:0] DEPTH_W   = RES_DEPTH[FAW:0];

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt1_q, cnt1_d, cnt2_q, cnt2_d, len1_q, len1_d, len2_q, len2_d;
    logic           ovf_q, ovf_d, err_q, err_d, start_q, start_d, abort_q, abort_d;
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FAW:0]   fcnt_q, fcnt_d;
    logic [31:0]    rdata_q, rdata_d, fcnt32, cycles_rd;
    logic [7:0]     fcnt_sat;
    logic [1:0]     seq1_mem_q [MAX_LEN];
    logic [1:0]     seq2_mem_q [MAX_LEN];
    logic [1:0]     fifo_mem_q [RES_DEPTH];
    logic [1:0]     seq1_base_q, seq2_base_q;
    logic           seq1_we, seq2_we;
    logic           wr_ctrl, do_clear, do_start, wr_len, wr_seq1, wr_seq2, rd_pop;
    logic           fifo_pop, fifo_push, start_ok;
    logic           unused_wdata;

    assign wr_ctrl  = avs_write && (avs_address == 3'd0);
    assign do_clear = wr_ctrl && avs_writedata[1];
    assign do_start = wr_ctrl && avs_writedata[0] && !avs_writedata[1];
    assign wr_len   = avs_write && (avs_address == 3'd1);
    assign wr_seq1  = avs_write && (avs_address == 3'd2);
    assign wr_seq2  = avs_write && (avs_address == 3'd3);
    assign rd_pop   = avs_read && (avs_address == 3'd4);

    assign fifo_pop  = rd_pop && (fcnt_q != '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a direction.
    assign dir_ready = (fcnt_q < DEPTH_W) || fifo_pop;
    assign fifo_push = (state_q == ST_RUN) && dir_valid && dir_ready;

    assign start_ok = (len1_q != 8'd0) && (len2_q != 8'd0) &&
                      (len1_q <= cnt1_q) && (len2_q <= cnt2_q) &&
                      ({1'b0, len1_q} <= MAX_LEN_W) && ({1'b0, len2_q} <= MAX_LEN_W);

    always_comb begin
        state_d  = state_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        len1_d   = len1_q;
        len2_d   = len2_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        seq1_we  = 1'b0;
        seq2_we  = 1'b0;
        wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (wr_len) begin
                    len1_d = avs_writedata[7:0];
                    len2_d = avs_writedata[15:8];
                end
                if (wr_seq1) begin
                    if ({1'b0, cnt1_q} < MAX_LEN_W) begin
                        seq1_we = 1'b1;
                        cnt1_d  = cnt1_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (wr_seq2) begin
                    if ({1'b0, cnt2_q} < MAX_LEN_W) begin
                        seq2_we = 1'b1;
                        cnt2_d  = cnt2_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (do_start) begin
                    if (start_ok) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (fifo_push && dir_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (fcnt_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear overrides everything else, including a start written in the same word.
        if (do_clear) begin
            state_d  = ST_IDLE;
            abort_d  = (state_q == ST_RUN);
            cnt1_d   = 8'd0;
            cnt2_d   = 8'd0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
            seq1_we  = 1'b0;
            seq2_we  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end
    end

`ifdef SEQ_PORT_CYCLES_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (do_clear || start_d) cycles_d = 32'd0;
        else if (state_q == ST_RUN) cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cycles_q <= 32'd0;
        else     cycles_q <= cycles_d;
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = 32'd0;
`endif

    assign fcnt32   = 32'(fcnt_q);
    assign fcnt_sat = (fcnt32 > 32'd255) ? 8'hFF : fcnt32[7:0];

    always_comb begin
        rdata_d = 32'd0;
        if (avs_read) begin
            case (avs_address)
                3'd0:    rdata_d = {16'h0, fcnt_sat, 4'h0, err_q, ovf_q, state_q};
                3'd4:    rdata_d = fifo_pop ? {1'b1, 29'h0, fifo_mem_q[rd_ptr_q]} : 32'd0;
                3'd5:    rdata_d = 32'h5EA1_0001;
                3'd6:    rdata_d = cycles_rd;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt1_q   <= 8'd0;
            cnt2_q   <= 8'd0;
            len1_q   <= 8'd0;
            len2_q   <= 8'd0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            len1_q   <= len1_d;
            len2_q   <= len2_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage arrays carry no reset; the counts and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (seq1_we)   seq1_mem_q[cnt1_q[SAW-1:0]] <= avs_writedata[1:0];
        if (seq2_we)   seq2_mem_q[cnt2_q[SAW-1:0]] <= avs_writedata[1:0];
        if (fifo_push) fifo_mem_q[wr_ptr_q]        <= dir_data;
        seq1_base_q <= ({1'b0, seq1_addr} < MAX_LEN_W) ? seq1_mem_q[seq1_addr[SAW-1:0]] : 2'd0;
        seq2_base_q <= ({1'b0, seq2_addr} < MAX_LEN_W) ? seq2_mem_q[seq2_addr[SAW-1:0]] : 2'd0;
    end

    assign unused_wdata    = ^avs_writedata[31:16];
    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = 1'b0;
    assign solve_start     = start_q;
    assign solve_abort     = abort_q;
    assign len1            = len1_q;
    assign len2            = len2_q;
    assign seq1_base       = seq1_base_q;
    assign seq2_base       = seq2_base_q;

endmodule

// File: tb/tb_seq_avalon_port.sv
// Directed bench for seq_avalon_port: register access, solve flow, error/overflow, FIFO full and clear.
module tb_seq_avalon_port;
    localparam int MAX_LEN   = 64;
    localparam int RES_DEPTH = 128;
`ifdef SEQ_PORT_CYCLES_EN
    localparam logic [31:0] CYC_EXP = 32'd17;
`else
    localparam logic [31:0] CYC_EXP = 32'd0;
`endif

    logic        clk, rst;
    logic [2:0]  avs_address;
    logic        avs_write, avs_read;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest, solve_start, solve_abort;
    logic [7:0]  len1, len2, seq1_addr, seq2_addr;
    logic [1:0]  seq1_base, seq2_base, dir_data;
    logic        dir_valid, dir_last, dir_ready;

    int n_checks = 0;
    int n_errors = 0;

    seq_avalon_port #(.MAX_LEN(MAX_LEN), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .solve_start(solve_start), .solve_abort(solve_abort), .len1(len1), .len2(len2),
        .seq1_addr(seq1_addr), .seq2_addr(seq2_addr), .seq1_base(seq1_base), .seq2_base(seq2_base),
        .dir_valid(dir_valid), .dir_data(dir_data), .dir_last(dir_last), .dir_ready(dir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic send_dir(input logic [1:0] d, input logic last);
        @(negedge clk);
        dir_valid = 1'b1; dir_data = d; dir_last = last;
        @(negedge clk);
        dir_valid = 1'b0; dir_last = 1'b0;
    endtask

    function automatic logic [1:0] fdir(input int i);
        return 2'((i % 3) + 1);
    endfunction

    function automatic logic [1:0] obase(input int i);
        return 2'((i + (i >> 2)) % 4);
    endfunction

    logic [31:0] rd;
    logic [1:0]  dirs [5];
    logic [1:0]  s1 [5];
    logic [1:0]  s2 [4];

    initial begin
        rst = 1'b1; avs_address = '0; avs_write = 0; avs_writedata = '0; avs_read = 0;
        seq1_addr = '0; seq2_addr = '0; dir_valid = 0; dir_data = '0; dir_last = 0;
        dirs = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        s1 = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd2};
        s2 = '{2'd2, 2'd2, 2'd1, 2'd0};
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_start", 32'(solve_start), 32'd0);
        chk("rst_abort", 32'(solve_abort), 32'd0);
        chk("rst_ready", 32'(dir_ready), 32'd1);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_lens", {16'h0, len2, len1}, 32'd0);
        chk("waitreq", 32'(avs_waitrequest), 32'd0);
        avs_rd(3'd0, rd); chk("rst_ctrl", rd, 32'd0);
        avs_rd(3'd5, rd); chk("id", rd, 32'h5EA1_0001);
        avs_rd(3'd7, rd); chk("reserved", rd, 32'd0);

        // Basic solve: ATCAG / GGCA
        for (int i = 0; i < 5; i++) avs_wr(3'd2, 32'(s1[i]));
        for (int i = 0; i < 4; i++) avs_wr(3'd3, 32'(s2[i]));
        avs_wr(3'd1, 32'h0405);
        chk("len_out", {16'h0, len2, len1}, 32'h0405);
        @(negedge clk); seq1_addr = 8'd1; seq2_addr = 8'd2;
        @(negedge clk);
        chk("seq1_base1", 32'(seq1_base), 32'd3);
        chk("seq2_base2", 32'(seq2_base), 32'd1);
        avs_wr(3'd0, 32'h1);
        chk("start_pulse", 32'(solve_start), 32'd1);
        @(negedge clk);
        chk("start_pulse_end", 32'(solve_start), 32'd0);
        avs_rd(3'd0, rd); chk("ctrl_run", rd, 32'h1);
        for (int i = 0; i < 5; i++) send_dir(dirs[i], i == 4);
        avs_rd(3'd0, rd); chk("ctrl_done", rd, 32'h0502);
        for (int i = 0; i < 5; i++) begin
            avs_rd(3'd4, rd); chk("pop_basic", rd, {1'b1, 29'h0, dirs[i]});
        end
        avs_rd(3'd0, rd); chk("ctrl_idle", rd, 32'h0);
        avs_rd(3'd4, rd); chk("pop_empty", rd, 32'h0);

        // Bad start: len1=5 with only 3 bases in seq1
        avs_wr(3'd0, 32'h2);
        for (int i = 0; i < 3; i++) begin
            avs_wr(3'd2, 32'(i));
            avs_wr(3'd3, 32'(i));
        end
        avs_wr(3'd1, 32'h0305);
        avs_wr(3'd0, 32'h1);
        chk("bad_no_start", 32'(solve_start), 32'd0);
        avs_rd(3'd0, rd); chk("bad_ctrl", rd, 32'h8);

        // Overflow
        avs_wr(3'd0, 32'h2);
        avs_rd(3'd0, rd); chk("clear_ctrl", rd, 32'h0);
        for (int i = 0; i < MAX_LEN; i++) avs_wr(3'd2, 32'(obase(i)));
        avs_wr(3'd2, 32'h3);
        avs_wr(3'd2, 32'h3);
        avs_rd(3'd0, rd); chk("ovf_ctrl", rd, 32'h4);
        @(negedge clk); seq1_addr = 8'(MAX_LEN - 1);
        @(negedge clk); chk("ovf_last_base", 32'(seq1_base), 32'(obase(MAX_LEN - 1)));
        seq1_addr = 8'd0;
        @(negedge clk); chk("ovf_first_base", 32'(seq1_base), 32'(obase(0)));
        seq1_addr = 8'd1;
        @(negedge clk); chk("ovf_second_base", 32'(seq1_base), 32'(obase(1)));

        // FIFO full
        avs_wr(3'd0, 32'h2);
        for (int i = 0; i < 2; i++) begin
            avs_wr(3'd2, 32'h0);
            avs_wr(3'd3, 32'h0);
        end
        avs_wr(3'd1, 32'h0202);
        avs_wr(3'd0, 32'h1);
        for (int i = 0; i < RES_DEPTH; i++) begin
            @(negedge clk);
            dir_valid = 1'b1; dir_data = fdir(i); dir_last = 1'b0;
        end
        @(negedge clk); dir_valid = 1'b0;
        chk("full_ready", 32'(dir_ready), 32'd0);
        avs_rd(3'd0, rd); chk("full_ctrl", rd, 32'h8001);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            avs_address = 3'd4; avs_read = 1'b1; dir_valid = 1'b1; dir_data = fdir(RES_DEPTH + i);
            #1 chk("full_pop_ready", 32'(dir_ready), 32'd1);
            @(negedge clk);
            avs_read = 1'b0; dir_valid = 1'b0;
            chk("full_pop_data", avs_readdata, {1'b1, 29'h0, fdir(i)});
        end
        avs_rd(3'd0, rd); chk("full_ctrl_hold", rd, 32'h8001);
        chk("full_ready_hold", 32'(dir_ready), 32'd0);
        for (int i = 2; i < RES_DEPTH + 2; i++) begin
            avs_rd(3'd4, rd); chk("drain_order", rd, {1'b1, 29'h0, fdir(i)});
        end
        avs_rd(3'd4, rd); chk("drain_empty", rd, 32'h0);

        // Clear mid-RUN with three results held
        for (int i = 0; i < 3; i++) send_dir(fdir(i), 1'b0);
        avs_rd(3'd0, rd); chk("run3_ctrl", rd, 32'h0301);
        avs_wr(3'd0, 32'h2);
        chk("abort_pulse", 32'(solve_abort), 32'd1);
        @(negedge clk);
        chk("abort_pulse_end", 32'(solve_abort), 32'd0);
        avs_rd(3'd0, rd); chk("abort_ctrl", rd, 32'h0);
        avs_wr(3'd2, 32'h3);
        @(negedge clk); seq1_addr = 8'd0;
        @(negedge clk); chk("push_after_clear", 32'(seq1_base), 32'd3);

        // CYCLES: RUN lasts 17 cycles
        avs_wr(3'd0, 32'h2);
        for (int i = 0; i < 2; i++) begin
            avs_wr(3'd2, 32'h1);
            avs_wr(3'd3, 32'h2);
        end
        avs_wr(3'd1, 32'h0202);
        avs_wr(3'd0, 32'h1);
        chk("cyc_start_pulse", 32'(solve_start), 32'd1);
        repeat (16) @(negedge clk);
        dir_valid = 1'b1; dir_data = 2'd1; dir_last = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0; dir_last = 1'b0;
        avs_rd(3'd6, rd); chk("cycles_done", rd, CYC_EXP);
        avs_rd(3'd4, rd); chk("cyc_pop", rd, 32'h8000_0001);
        avs_rd(3'd0, rd); chk("cyc_idle", rd, 32'h0);
        avs_rd(3'd6, rd); chk("cycles_hold", rd, CYC_EXP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_avalon_port.md
# seq_avalon_port

Avalon-MM responder behind the HPS lightweight bridge that feeds the sequence-alignment accelerator. The ARM writes lengths and DNA bases into two on-chip sequence buffers, starts a solve, then pops the aligned direction stream back out. On its far side the block presents a start pulse, indexed sequence read ports and a valid/ready result input to the solver core.

## Interface
- MAX_LEN, 64: capacity of each sequence buffer, in bases; power of two, at most 255.
- RES_DEPTH, 128: result FIFO depth, in directions; power of two, at least 2*MAX_LEN.
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  reset; synchronous, active-high.
- avs_address  in  3  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data; valid one cycle after avs_read.
- avs_waitrequest  out  1  tied 0.
- solve_start  out  1  one-cycle pulse that starts the solver.
- solve_abort  out  1  one-cycle pulse; solver returns to idle.
- len1, len2  out  8  sequence lengths, stable while RUN.
- seq1_addr, seq2_addr  in  8  base index.
- seq1_base, seq2_base  out  2  base at the index, registered one cycle.
- dir_valid  in  1  direction valid.
- dir_data  in  2  direction.
- dir_last  in  1  final direction of the alignment.
- dir_ready  out  1  result FIFO not full.

## Operation
- Base encoding: A=0, C=1, G=2, T=3. Direction encoding: Diagonal=1, Above=2, Left=3; 0 is reserved.
- Register map (word address):
  - 0 CTRL. Write bit0 = start, bit1 = clear. Read gives: [1:0] state, [2] overflow, [3] error, [15:8] result count.
  - 1 LEN. Write sets [7:0] len1 and [15:8] len2.
  - 2 SEQ1_PUSH. Write appends [1:0] to seq1.
  - 3 SEQ2_PUSH. Write appends [1:0] to seq2.
  - 4 RESULT_POP. Read returns [31] valid and [1:0] direction, then pops.
  - 5 ID. Reads 32'h5EA1_0001.
  - 6 CYCLES. See Configuration.
  - 7 reserved. Reads 0.
- States: IDLE=0, RUN=1, DONE=2.
- IDLE:
  - LEN and SEQ pushes are accepted.
  - A start with len1 and len2 both in 1..pushed count, and both ≤ MAX_LEN, pulses solve_start and enters RUN.
  - Any other start sets error (sticky) and stays in IDLE.
- RUN:
  - LEN and SEQ writes are ignored.
  - Directions are accepted when dir_valid && dir_ready.
  - Accepting a direction with dir_last set moves to DONE.
- DONE: moves to IDLE on the cycle the FIFO becomes empty. Sequence buffers and lengths are retained, so a re-start without reloading is legal.
- Clear, in any state:
  - Empties both buffers and the FIFO.
  - Clears overflow, error and the pushed counts.
  - Pulses solve_abort if the block was in RUN.
  - Enters IDLE.
- Clear and start written together: clear wins.
- Push to a full buffer: the base is dropped and overflow is set (sticky).
- Pop from an empty FIFO: returns valid=0 and changes nothing.
- FIFO push and pop in the same cycle: both take effect, including when the FIFO is full, so the count is unchanged.
- dir_ready = (count < RES_DEPTH) || pop this cycle.

## Timing
- Reset values:
  - state IDLE; all counts 0; overflow and error 0.
  - solve_start, solve_abort 0; dir_ready 1; avs_readdata 0; len1, len2 0.
- Read latency is fixed at one cycle and waitrequest is never asserted. The RESULT_POP pop takes effect in the same cycle as avs_read.
- A write takes effect on the clock edge on which it is presented. Status reflects it from the next read.
- solve_start is asserted the cycle after the start write. The state reads as RUN from that same cycle.
- seqN_base gives the base at seqN_addr with one-cycle latency.
- The CTRL result count saturates at 255 on read.

## Configuration
- SEQ_PORT_CYCLES_EN defined: a 32-bit counter clears on solve_start, increments every cycle in RUN, and holds in IDLE and DONE. Address 6 reads the counter. Clear and rst zero it.
- Macro undefined: the counter is not built and address 6 reads 0.

## Test plan
- Basic solve:
  - Stimulus: reset; push seq1 ATCAG and seq2 GGCA; write LEN 0x0405; write start.
  - Required: solve_start pulses one cycle after the start write; CTRL[1:0]=1.
  - Stimulus: a model solver emits 5 directions (last on the 5th).
  - Required: state=2; five pops return valid=1 with the values in order; state=0; a sixth pop returns 0.
- Bad start:
  - Stimulus: LEN 0x0305 with only 3 bases pushed to seq1; start.
  - Required: error=1; no solve_start; state stays 0.
- Overflow:
  - Stimulus: MAX_LEN+2 pushes to seq1.
  - Required: overflow=1; seq1_addr=MAX_LEN-1 returns the MAX_LEN-th base.
- FIFO full:
  - Stimulus: fill the FIFO to RES_DEPTH.
  - Required: dir_ready=0.
  - Stimulus: pop while dir_valid is held high.
  - Required: count stays RES_DEPTH; values stay in order.
- Clear mid-RUN:
  - Stimulus: write clear while in RUN with 3 results held.
  - Required: solve_abort pulses; count=0; state=0; pushes are accepted again.
- CYCLES:
  - Stimulus: the solver takes 17 cycles.
  - Required: with SEQ_PORT_CYCLES_EN, CYCLES reads 17; without it, CYCLES reads 0.
